// File: rtl/jtframe_sdram_rq.sv
// One client slot of an SDRAM arbiter: address mapping, small word cache,
// request generation and fill capture.
// Optional write support is enabled by defining JTFRAME_RQ_WRITE_EN.
module jtframe_sdram_rq #(
  parameter int unsigned SDRAMW  = 22,
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 8,
  parameter int unsigned LATCH   = 0,
  parameter int unsigned DOUBLE  = 0,
  parameter int unsigned OKLATCH = 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [SDRAMW-1:0] offset,
  input  logic [AW-1:0]     addr,
  input  logic              addr_ok,
  input  logic [DW-1:0]     wrdata,
  input  logic              wrin,
  output logic              req_rnw,
  output logic [SDRAMW-1:0] sdram_addr,
  input  logic [15:0]       din,
  input  logic              din_ok,
  input  logic              dst,
  output logic [DW-1:0]     dout,
  output logic              req,
  output logic              data_ok,
  input  logic              we
);

  // word address is one bit wider than the client address to cover DW=32
  localparam int unsigned WW = AW + 1;
  // cache entry payload: a full SDRAM word, or two for 32-bit clients
  localparam int unsigned ED = (DW == 32) ? 32 : 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HIGH = 1'b1
  } fill_st_t;

  logic              w_wrin_live;
  logic [AW-1:0]     w_addr;
  logic              w_addr_ok;
  logic              w_wrin;
  logic [WW-1:0]     w_word;
  logic              w_rd;
  logic [1:0]        w_hit;
  logic              w_any_hit;
  logic [ED-1:0]     w_hit_data;
  logic [DW-1:0]     w_sel;
  logic              w_repl;
  logic              w_rd_req;
  logic              w_beat;
  logic              w_first;
  logic              w_fill_end;
  logic [WW-1:0]     w_fill_tag;
  logic              w_fill_idx;
  logic [ED-1:0]     w_fill_data;
  logic              w_wr_req;
  logic              w_wr_end;
  logic              w_wr_ok;
  logic              w_ok_c;

  fill_st_t          r_st;
  fill_st_t          w_st_nx;
  logic [15:0]       r_lo;
  logic [WW-1:0]     r_fill_tag;
  logic              r_fill_idx;
  logic [1:0]        r_valid;
  logic [WW-1:0]     r_tag  [2];
  logic [ED-1:0]     r_data [2];
  logic              r_lru;
  logic [DW-1:0]     r_dout;
  logic              r_ok;

`ifdef JTFRAME_RQ_WRITE_EN
  assign w_wrin_live = wrin;
`else
  assign w_wrin_live = 1'b0;
`endif

  // optional one-cycle input stage for timing relief
  generate
    if (LATCH != 0) begin : g_latch
      logic [AW-1:0] r_addr;
      logic          r_addr_ok;
      logic          r_wrin;
      // register client address, strobe and direction
      always_ff @(posedge clk) begin
        if (rst) begin
          r_addr    <= '0;
          r_addr_ok <= 1'b0;
          r_wrin    <= 1'b0;
        end else begin
          r_addr    <= addr;
          r_addr_ok <= addr_ok;
          r_wrin    <= w_wrin_live;
        end
      end
      assign w_addr    = r_addr;
      assign w_addr_ok = r_addr_ok;
      assign w_wrin    = r_wrin;
    end else begin : g_live
      assign w_addr    = addr;
      assign w_addr_ok = addr_ok;
      assign w_wrin    = w_wrin_live;
    end
  endgenerate

  // client address to SDRAM word address
  generate
    if (DW == 8) begin : g_word8
      assign w_word = WW'(w_addr >> 1);
    end else if (DW == 16) begin : g_word16
      assign w_word = WW'(w_addr);
    end else begin : g_word32
      assign w_word = {w_addr, 1'b0};
    end
  endgenerate

  assign sdram_addr = offset + SDRAMW'(w_word);

  // cache lookup
  assign w_rd       = w_addr_ok & ~w_wrin;
  assign w_hit[0]   = w_rd & r_valid[0] & (r_tag[0] == w_word);
  assign w_hit[1]   = (DOUBLE != 0) & w_rd & r_valid[1] & (r_tag[1] == w_word);
  assign w_any_hit  = |w_hit;
  assign w_hit_data = w_hit[1] ? r_data[1] : r_data[0];
  assign w_repl     = (DOUBLE != 0) ? r_lru : 1'b0;

  // client-facing data lane selection
  generate
    if (DW == 8) begin : g_sel8
      assign w_sel = w_addr[0] ? w_hit_data[15:8] : w_hit_data[7:0];
    end else begin : g_selw
      assign w_sel = w_hit_data;
    end
  endgenerate

  assign dout = w_any_hit ? w_sel : r_dout;

  // hold the last delivered data when nothing hits
  always_ff @(posedge clk) begin
    if (rst) r_dout <= '0;
    else     r_dout <= dout;
  end

  assign w_rd_req = w_rd & ~w_any_hit;
  assign w_beat   = we & din_ok;
  assign w_first  = (r_st == ST_IDLE) & w_rd_req & w_beat & dst;

  // fill sequencer state register
  always_ff @(posedge clk) begin
    if (rst) r_st <= ST_IDLE;
    else     r_st <= w_st_nx;
  end

  // fill sequencer next state: one beat for DW<=16, two for DW=32
  always_comb begin
    w_st_nx    = r_st;
    w_fill_end = 1'b0;
    case (r_st)
      ST_IDLE: begin
        if (w_first) begin
          if (DW == 32) w_st_nx    = ST_HIGH;
          else          w_fill_end = 1'b1;
        end
      end
      ST_HIGH: begin
        if (w_beat) begin
          w_st_nx    = ST_IDLE;
          w_fill_end = 1'b1;
        end
      end
      default: w_st_nx = ST_IDLE;
    endcase
  end

  // first-beat capture locks the fill target against address changes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo       <= '0;
      r_fill_tag <= '0;
      r_fill_idx <= 1'b0;
    end else if (w_first) begin
      r_lo       <= din;
      r_fill_tag <= w_word;
      r_fill_idx <= w_repl;
    end
  end

  assign w_fill_tag = (r_st == ST_HIGH) ? r_fill_tag : w_word;
  assign w_fill_idx = (r_st == ST_HIGH) ? r_fill_idx : w_repl;

  generate
    if (ED == 32) begin : g_fill32
      assign w_fill_data = {din, r_lo};
    end else begin : g_fill16
      assign w_fill_data = din;
    end
  endgenerate

`ifdef JTFRAME_RQ_WRITE_EN
  logic          r_wr_done;
  logic [AW-1:0] r_wr_addr;
  logic          w_wr;
  assign w_wr     = w_addr_ok & w_wrin;
  assign w_wr_req = w_wr & ~r_wr_done;
  assign w_wr_end = w_wr_req & w_beat;
  assign w_wr_ok  = w_wr & r_wr_done;

  // write completion flag, cleared once the client moves on
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_done <= 1'b0;
      r_wr_addr <= '0;
    end else if (w_wr_end) begin
      r_wr_done <= 1'b1;
      r_wr_addr <= w_addr;
    end else if (!w_addr_ok || (w_addr != r_wr_addr)) begin
      r_wr_done <= 1'b0;
    end
  end
`else
  assign w_wr_req = 1'b0;
  assign w_wr_end = 1'b0;
  assign w_wr_ok  = 1'b0;
`endif

  // cache entries: clear, write invalidation, LRU tracking, then fill (fill wins)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_lru   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (clr) r_valid <= '0;
      if (w_wr_end) begin
        for (int i = 0; i < 2; i++) begin
          if (r_tag[i] == w_word) r_valid[i] <= 1'b0;
        end
      end
      if (w_hit[0])      r_lru <= 1'b1;
      else if (w_hit[1]) r_lru <= 1'b0;
      if (w_fill_end) begin
        r_valid[w_fill_idx] <= 1'b1;
        r_tag[w_fill_idx]   <= w_fill_tag;
        r_data[w_fill_idx]  <= w_fill_data;
        r_lru               <= ~w_fill_idx;
      end
    end
  end

  assign req     = w_rd_req | (r_st == ST_HIGH) | w_wr_req;
  assign req_rnw = ~w_wr_req;

  assign w_ok_c = w_any_hit | w_wr_ok;

  // registered data_ok variant
  always_ff @(posedge clk) begin
    if (rst) r_ok <= 1'b0;
    else     r_ok <= w_ok_c;
  end

  assign data_ok = (OKLATCH != 0) ? r_ok : w_ok_c;

  logic w_unused;
  assign w_unused = ^{wrdata, wrin, r_lo};

endmodule

// File: tb/tb_jtframe_sdram_rq.sv
// Scoreboard bench for jtframe_sdram_rq: three slot configurations
// (DW=16 two-entry, DW=8 one-entry combinational ok, DW=32 one-entry).
module tb_jtframe_sdram_rq;

  logic        clk;
  logic        rst;
  logic        clr;
  logic [21:0] offset;
  logic [15:0] din;
  logic        din_ok;
  logic        dst;

  logic [7:0]  addr_v [3];
  logic [2:0]  aok;
  logic [2:0]  wev;
  logic [2:0]  wrin_v;
  logic [15:0] wd16;
  logic [7:0]  wd8;
  logic [31:0] wd32;

  logic [2:0]  req_v;
  logic [2:0]  rnw_v;
  logic [2:0]  dok_v;
  logic [21:0] sa_v [3];
  logic [15:0] dout16;
  logic [7:0]  dout8;
  logic [31:0] dout32;

  int          checks;
  int          fails;
  logic [2:0]  taken;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];

  jtframe_sdram_rq #(.SDRAMW(22), .AW(8), .DW(16), .LATCH(0), .DOUBLE(1), .OKLATCH(1)) u_dut16 (
    .clk(clk), .rst(rst), .clr(clr), .offset(offset), .addr(addr_v[0]), .addr_ok(aok[0]),
    .wrdata(wd16), .wrin(wrin_v[0]), .req_rnw(rnw_v[0]), .sdram_addr(sa_v[0]), .din(din),
    .din_ok(din_ok), .dst(dst), .dout(dout16), .req(req_v[0]), .data_ok(dok_v[0]), .we(wev[0]));

  jtframe_sdram_rq #(.SDRAMW(22), .AW(8), .DW(8), .LATCH(0), .DOUBLE(0), .OKLATCH(0)) u_dut8 (
    .clk(clk), .rst(rst), .clr(clr), .offset(offset), .addr(addr_v[1]), .addr_ok(aok[1]),
    .wrdata(wd8), .wrin(wrin_v[1]), .req_rnw(rnw_v[1]), .sdram_addr(sa_v[1]), .din(din),
    .din_ok(din_ok), .dst(dst), .dout(dout8), .req(req_v[1]), .data_ok(dok_v[1]), .we(wev[1]));

  jtframe_sdram_rq #(.SDRAMW(22), .AW(8), .DW(32), .LATCH(0), .DOUBLE(0), .OKLATCH(1)) u_dut32 (
    .clk(clk), .rst(rst), .clr(clr), .offset(offset), .addr(addr_v[2]), .addr_ok(aok[2]),
    .wrdata(wd32), .wrin(wrin_v[2]), .req_rnw(rnw_v[2]), .sdram_addr(sa_v[2]), .din(din),
    .din_ok(din_ok), .dst(dst), .dout(dout32), .req(req_v[2]), .data_ok(dok_v[2]), .we(wev[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void qpush(input int k, input logic [31:0] v);
    case (k)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [31:0] qpop(input int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic logic [31:0] dut_dout(input int k);
    case (k)
      0:       return {16'h0, dout16};
      1:       return {24'h0, dout8};
      default: return dout32;
    endcase
  endfunction

  // wait for the monitor to consume the pending expectation, bounded
  task automatic wait_taken(input int k);
    int n;
    n = 0;
    while (!taken[k] && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    if (!taken[k]) begin
      chk("data_ok_timeout", 32'(dok_v[k]), 32'h1);
      if (qsize(k) != 0) void'(qpop(k));
    end
  endtask

  // read transaction; the bench plays the arbiter when a miss is expected
  task automatic rd(input int k, input logic [7:0] a, input logic exp_req,
                    input logic [15:0] b0, input logic [15:0] b1,
                    input logic [31:0] exp_d, input logic [21:0] exp_sa);
    qpush(k, exp_d);
    addr_v[k] = a;
    aok[k]    = 1'b1;
    #1;
    chk("req", 32'(req_v[k]), 32'(exp_req));
    chk("sdram_addr", 32'(sa_v[k]), 32'(exp_sa));
    chk("req_rnw", 32'(rnw_v[k]), 32'h1);
    if (exp_req) begin
      wev[k] = 1'b1; din_ok = 1'b1; dst = 1'b1; din = b0;
      @(posedge clk); #1;
      if (k == 2) begin
        dst = 1'b0; din = b1;
        chk("req_mid_burst", 32'(req_v[k]), 32'h1);
        @(posedge clk); #1;
      end
      wev[k] = 1'b0; din_ok = 1'b0; dst = 1'b0;
      chk("req_after_fill", 32'(req_v[k]), 32'h0);
    end
    wait_taken(k);
    aok[k] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

`ifdef JTFRAME_RQ_WRITE_EN
  // write transaction on the DW=16 slot
  task automatic wr16(input logic [7:0] a, input logic [15:0] d, input logic [31:0] exp_hold);
    qpush(0, exp_hold);
    addr_v[0] = a; wd16 = d; wrin_v[0] = 1'b1; aok[0] = 1'b1;
    #1;
    chk("wr_req", 32'(req_v[0]), 32'h1);
    chk("wr_req_rnw", 32'(rnw_v[0]), 32'h0);
    wev[0] = 1'b1; din_ok = 1'b1;
    @(posedge clk); #1;
    wev[0] = 1'b0; din_ok = 1'b0;
    chk("wr_req_after", 32'(req_v[0]), 32'h0);
    wait_taken(0);
    aok[0] = 1'b0; wrin_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask
`endif

  initial begin
    checks = 0; fails = 0; taken = '0;
    rst = 1'b1; clr = 1'b0; offset = 22'h100;
    din = '0; din_ok = 1'b0; dst = 1'b0;
    for (int i = 0; i < 3; i++) addr_v[i] = '0;
    aok = '0; wev = '0; wrin_v = '0; wd16 = '0; wd8 = '0; wd32 = '0;

    // monitor: pop and compare on each new data_ok assertion
    fork
      forever begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          if (dok_v[k] && !taken[k]) begin
            taken[k] = 1'b1;
            if (qsize(k) == 0) begin
              checks++; fails++;
              $display("FAIL data_ok_unexpected slot=%0d actual=1 required=0", k);
            end else begin
              chk("dout", dut_dout(k), qpop(k));
            end
          end else if (!dok_v[k]) begin
            taken[k] = 1'b0;
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req", 32'(req_v), 32'h0);
    chk("rst_req_rnw", 32'(rnw_v), 32'h7);
    chk("rst_data_ok", 32'(dok_v), 32'h0);
    chk("rst_dout16", 32'(dout16), 32'h0);
    chk("rst_dout8", 32'(dout8), 32'h0);
    chk("rst_dout32", dout32, 32'h0);

    // DW=16: basic miss/fill, then hit
    rd(0, 8'h05, 1'b1, 16'hBEEF, 16'h0, 32'hBEEF, 22'h105);
    rd(0, 8'h05, 1'b0, 16'h0, 16'h0, 32'hBEEF, 22'h105);
    // two-entry LRU replacement
    rd(0, 8'h10, 1'b1, 16'h1010, 16'h0, 32'h1010, 22'h110);
    rd(0, 8'h20, 1'b1, 16'h2020, 16'h0, 32'h2020, 22'h120);
    rd(0, 8'h10, 1'b0, 16'h0, 16'h0, 32'h1010, 22'h110);
    rd(0, 8'h30, 1'b1, 16'h3030, 16'h0, 32'h3030, 22'h130);
    rd(0, 8'h20, 1'b1, 16'h2222, 16'h0, 32'h2222, 22'h120);
    rd(0, 8'h30, 1'b0, 16'h0, 16'h0, 32'h3030, 22'h130);
    // clr invalidates a valid entry
    rd(0, 8'h05, 1'b1, 16'h0505, 16'h0, 32'h0505, 22'h105);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk); #1;
    rd(0, 8'h05, 1'b1, 16'h5555, 16'h0, 32'h5555, 22'h105);
`ifdef JTFRAME_RQ_WRITE_EN
    // write completes, then invalidates the cached copy
    wr16(8'h05, 16'hA5A5, 32'h5555);
    rd(0, 8'h05, 1'b1, 16'h6666, 16'h0, 32'h6666, 22'h105);
`endif

    // DW=8: byte lanes from one cached word
    rd(1, 8'h06, 1'b1, 16'h12AB, 16'h0, 32'hAB, 22'h103);
`ifndef JTFRAME_RQ_WRITE_EN
    wrin_v[1] = 1'b1;
`endif
    rd(1, 8'h07, 1'b0, 16'h0, 16'h0, 32'h12, 22'h103);
    wrin_v[1] = 1'b0;
    chk("dout8_hold", 32'(dout8), 32'h12);
    // address sum wraps at 2^22
    offset = 22'h3FFFFF; addr_v[1] = 8'h04;
    #1;
    chk("sdram_addr_wrap", 32'(sa_v[1]), 32'h000001);
    offset = 22'h100;
    @(negedge clk); #1;

    // DW=32: two-beat fill, hit, replacement
    rd(2, 8'h03, 1'b1, 16'h1111, 16'h2222, 32'h22221111, 22'h106);
    rd(2, 8'h03, 1'b0, 16'h0, 16'h0, 32'h22221111, 22'h106);
    rd(2, 8'h80, 1'b1, 16'hAAAA, 16'hBBBB, 32'hBBBBAAAA, 22'h200);

    // reset in the middle of a two-beat fill; stray beat must be ignored
    addr_v[2] = 8'h03; aok[2] = 1'b1;
    #1;
    chk("midfill_req", 32'(req_v[2]), 32'h1);
    wev[2] = 1'b1; din_ok = 1'b1; dst = 1'b1; din = 16'h7777;
    @(posedge clk); #1;
    wev[2] = 1'b0; din_ok = 1'b0; dst = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wev[2] = 1'b1; din_ok = 1'b1; din = 16'h9999;
    @(posedge clk); #1;
    wev[2] = 1'b0; din_ok = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("midfill_req_after_rst", 32'(req_v[2]), 32'h1);
    chk("midfill_data_ok", 32'(dok_v[2]), 32'h0);
    chk("midfill_dout32", dout32, 32'h0);
    aok[2] = 1'b0;
    repeat (2) @(negedge clk);

    chk("scoreboard_empty", 32'(q0.size() + q1.size() + q2.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
